// File: rtl/trace_udma_rx_arbiter.sv
// Round-robin, packet-atomic arbiter that feeds trace packets into the uDMA RX
// channel through a single output register, and discards packets while RX is off.
module trace_udma_rx_arbiter #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [16*NUM_SRC-1:0] src_data_i,
    input  logic [NUM_SRC-1:0]    src_valid_i,
    input  logic [NUM_SRC-1:0]    src_last_i,
    output logic [NUM_SRC-1:0]    src_ready_o,
    input  logic                  rx_en_i,
    output logic [15:0]           data_rx_data_o,
    output logic                  data_rx_valid_o,
    input  logic                  data_rx_ready_i,
    output logic [1:0]            data_rx_datasize_o,
    input  logic                  drop_clr_i,
    output logic [CNT_W-1:0]      drop_cnt_o,
    output logic                  busy_o
);

    localparam int unsigned PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        DROP
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [PW-1:0]   grant_inc;
    logic [PW-1:0]   pick;
    logic            found;
    logic            out_valid_q;
    logic [15:0]     out_data_q;
    logic            can_load;
    logic            fwd_fire;
    logic            drop_fire;
    logic            out_clr_drop;
    logic            cur_valid;
    logic            cur_last;
    logic [15:0]     cur_data;
    logic [1:0]      inc;
    logic [CNT_W:0]  sum;
    logic [CNT_W-1:0] drop_q;

    assign can_load     = !out_valid_q || data_rx_ready_i;
    assign cur_valid    = src_valid_i[grant_q];
    assign cur_last     = src_last_i[grant_q];
    assign cur_data     = src_data_i[16*grant_q +: 16];
    assign out_clr_drop = !rx_en_i && out_valid_q;
    assign grant_inc    = (32'(grant_q) == NUM_SRC - 1) ? '0 : grant_q + 1'b1;

    // First requesting source at or after the round-robin pointer
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            idx = (32'(rr_q) + i) % NUM_SRC;
            if (!found && src_valid_i[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    // Packet FSM: next state, grant, pointer and source handshakes
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        src_ready_o = '0;
        fwd_fire    = 1'b0;
        drop_fire   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_en_i && found) begin
                    grant_d = pick;
                    state_d = FWD;
                end
            end
            FWD: begin
                if (!rx_en_i) begin
                    state_d = DROP;
                end else begin
                    src_ready_o[grant_q] = can_load;
                    if (can_load && cur_valid) begin
                        fwd_fire = 1'b1;
                        if (cur_last) begin
                            rr_d    = grant_inc;
                            state_d = IDLE;
                        end
                    end
                end
            end
            DROP: begin
                src_ready_o[grant_q] = 1'b1;
                if (cur_valid) begin
                    drop_fire = 1'b1;
                    if (cur_last) begin
                        rr_d    = grant_inc;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, grant and round-robin pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    // Output register; flushed whenever the RX channel is disabled
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (!rx_en_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (can_load) begin
            out_valid_q <= fwd_fire;
            if (fwd_fire) begin
                out_data_q <= cur_data;
            end
        end
    end

    // A drained beat and a flushed output beat can both count in one cycle
    always_comb begin
        inc = 2'(drop_fire) + 2'(out_clr_drop);
        sum = {1'b0, drop_q} + (CNT_W+1)'(inc);
    end

    // Saturating dropped-beat counter, clear wins over increments
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_q <= '0;
        end else if (drop_clr_i) begin
            drop_q <= '0;
        end else if (sum[CNT_W]) begin
            drop_q <= '1;
        end else begin
            drop_q <= sum[CNT_W-1:0];
        end
    end

    assign data_rx_data_o     = out_data_q;
    assign data_rx_valid_o    = out_valid_q;
    assign data_rx_datasize_o = 2'b01;
    assign drop_cnt_o         = drop_q;
    assign busy_o             = (state_q != IDLE) || out_valid_q;

endmodule
